// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the elastic pipeline stage
//
// Purpose : state encoding, default ID/EX bundle widths and pack/unpack
//           helpers that map named ID/EX fields onto flat ctrl/data vectors.
// Ports   : none (package).
package pipe_pkg;

  localparam int IDEX_CTRL_W = 12;
  localparam int IDEX_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // 12 control bits; an all-zero bundle is a NOP.
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic       regdst;
    logic [3:0] alucontrol;
  } idex_ctrl_t;

  // 128 data bits: two operands, pc+4, 16-bit immediate, three register ids.
  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc_plus4;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        pad;
  } idex_data_t;

  function automatic logic [IDEX_CTRL_W-1:0] pack_ctrl(input idex_ctrl_t c);
    return c;
  endfunction

  function automatic idex_ctrl_t unpack_ctrl(input logic [IDEX_CTRL_W-1:0] v);
    return v;
  endfunction

  function automatic logic [IDEX_DATA_W-1:0] pack_data(input idex_data_t d);
    return d;
  endfunction

  function automatic idex_data_t unpack_data(input logic [IDEX_DATA_W-1:0] v);
    return v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Purpose : counts cycles with inc=1, sticking at all-ones instead of wrapping.
// Ports   : clk   - clock
//           rst_n - synchronous active-low reset, clears the count
//           inc   - increment request for this cycle
//           count - current count value
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with 2-entry skid buffer
//
// Purpose : carries a ctrl/data bundle between two pipeline stages with a
//           valid/ready handshake. in_ready is registered, so downstream
//           backpressure never reaches upstream combinationally. Flush
//           inserts a bubble; stall/bubble counters saturate.
// Ports   : clk, rst_n              - clock, synchronous active-low reset
//           in_valid/in_ready       - upstream handshake (in_ready registered)
//           in_ctrl/in_data         - upstream bundle
//           flush                   - drop held entries and this cycle's input
//           out_valid/out_ready     - downstream handshake
//           out_ctrl/out_data       - output bundle, zero when out_valid=0
//           stall_cnt/bubble_cnt    - saturating performance counters
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              main_vld_q, main_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  // Skid validity is exactly (state == ST_FULL), so it needs no flop of its own.
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic take;

  assign accept = in_valid && in_ready_q;
  assign take   = main_vld_q && out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && take) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          state_d     = ST_FULL;
        end else if (take) begin
          // Clear on drain so the idle outputs read as a NOP bundle.
          main_ctrl_d = '0;
          main_data_d = '0;
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (take) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
          skid_data_d = '0;
          state_d     = ST_ONE;
        end
      end
      default: begin
        main_ctrl_d = '0;
        main_data_d = '0;
        skid_ctrl_d = '0;
        skid_data_d = '0;
        state_d     = ST_EMPTY;
      end
    endcase

    if (flush) begin
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
      state_d     = ST_EMPTY;
    end

    // Handshake flags are precomputed from the next state so that the
    // outputs come straight from flops.
    in_ready_d = (state_d != ST_FULL);
    main_vld_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (main_vld_q && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!main_vld_q),
    .count (bubble_cnt)
  );

endmodule
